// File: rtl/sad_pkg.sv
// sad_pkg
// Shared definitions for the SAD search scheduler slice.
//   SAD_W_DEFAULT : default width of a SAD result
//   SAD_MAX       : all-ones SAD, the "nothing found yet" value of the minimum tracker
//   sad_sched_state_t : scheduler FSM states
package sad_pkg;

   localparam int SAD_W_DEFAULT = 32;
   localparam logic [SAD_W_DEFAULT-1:0] SAD_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_UPDATE,
      S_FINISH
   } sad_sched_state_t;

endpackage

// File: rtl/sad_search_ctrl_if.sv
// sad_search_ctrl_if
// Bundles the host request/status signals and the SAD engine handshake of the
// search scheduler.
//   master : host + engine side (drives start/abort/num_cand/sad_done/sad)
//   slave  : the scheduler (drives sad_go/cand_idx/busy/done/err/best_*)
interface sad_search_ctrl_if
   import sad_pkg::*;
#(
   parameter int N_CAND = 8,
   parameter int SAD_W  = SAD_W_DEFAULT
);

   localparam int IW = (N_CAND > 1) ? $clog2(N_CAND) : 1;
   localparam int CW = $clog2(N_CAND + 1);

   logic             start;
   logic             abort;
   logic [CW-1:0]    num_cand;
   logic             sad_done;
   logic [SAD_W-1:0] sad;
   logic             sad_go;
   logic [IW-1:0]    cand_idx;
   logic             busy;
   logic             done;
   logic             err;
   logic [SAD_W-1:0] best_sad;
   logic [IW-1:0]    best_idx;

   modport master (
      output start, abort, num_cand, sad_done, sad,
      input  sad_go, cand_idx, busy, done, err, best_sad, best_idx
   );

   modport slave (
      input  start, abort, num_cand, sad_done, sad,
      output sad_go, cand_idx, busy, done, err, best_sad, best_idx
   );

endinterface

// File: rtl/sad_min_tracker.sv
// sad_min_tracker
// Keeps the running minimum SAD and the candidate index that produced it.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : return best_sad/best_idx to all-ones / zero
//   load     : offer sad/idx as a new candidate result
//   sad, idx : candidate result and its index
//   best_sad, best_idx : registered running minimum and its index
module sad_min_tracker
   import sad_pkg::*;
#(
   parameter int SAD_W = SAD_W_DEFAULT,
   parameter int IW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [SAD_W-1:0] sad,
   input  logic [IW-1:0]    idx,
   output logic [SAD_W-1:0] best_sad,
   output logic [IW-1:0]    best_idx
);

   // Only a strictly smaller SAD replaces the current best, so among equal
   // results the earliest (lowest) candidate index wins; clear beats load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_sad <= '1;
         best_idx <= '0;
      end else if (clear) begin
         best_sad <= '1;
         best_idx <= '0;
      end else if (load && (sad < best_sad)) begin
         best_sad <= sad;
         best_idx <= idx;
      end
   end

endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl
// Full-search scheduler above the single-block SAD engine: runs the engine once
// per candidate, presents the candidate index to the engine, and tracks the
// minimum SAD. A per-candidate watchdog ends the search with err if the engine
// never answers.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave modport of sad_search_ctrl_if (request, engine handshake,
//              status and best result)
module sad_search_ctrl
   import sad_pkg::*;
#(
   parameter int N_CAND  = 8,
   parameter int SAD_W   = SAD_W_DEFAULT,
   parameter int TIMEOUT = 1024
) (
   input logic               clk,
   input logic               rst,
   sad_search_ctrl_if.slave  bus
);

   localparam int IW = (N_CAND > 1) ? $clog2(N_CAND) : 1;
   localparam int CW = $clog2(N_CAND + 1);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   sad_sched_state_t state;
   sad_sched_state_t state_next;

   logic [CW-1:0]    n;
   logic [CW-1:0]    n_clamped;
   logic [IW-1:0]    cand_idx;
   logic [WW-1:0]    wait_cnt;
   logic [SAD_W-1:0] sad_cap;
   logic             err;
   logic             accept;
   logic             aborting;
   logic             last_cand;
   logic             timed_out;
   logic             track_clear;
   logic             track_load;
   logic [SAD_W-1:0] best_sad;
   logic [IW-1:0]    best_idx;

   // Next-state logic. Abort is applied last so it overrides every other
   // transition out of a non-idle state; within WAIT a completing engine wins
   // over the watchdog expiring in the same cycle.
   always_comb begin
      n_clamped   = (bus.num_cand > CW'(N_CAND)) ? CW'(N_CAND) : bus.num_cand;
      accept      = (state == S_IDLE) && bus.start && !bus.abort;
      aborting    = (state != S_IDLE) && bus.abort;
      last_cand   = (CW'(cand_idx) == (n - CW'(1)));
      timed_out   = (wait_cnt == WW'(TIMEOUT - 1));
      state_next  = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_next = (n_clamped == '0) ? S_FINISH : S_LAUNCH;
            end
         end
         S_LAUNCH: state_next = S_WAIT;
         S_WAIT: begin
            if (bus.sad_done) begin
               state_next = S_UPDATE;
            end else if (timed_out) begin
               state_next = S_FINISH;
            end
         end
         S_UPDATE: state_next = last_cand ? S_FINISH : S_LAUNCH;
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (aborting) begin
         state_next = S_IDLE;
      end
      track_clear = accept || aborting;
      track_load  = (state == S_UPDATE) && !bus.abort;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Search datapath: candidate count, candidate index, watchdog counter and
   // the captured engine result. err survives an abort and is only cleared
   // by the next accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n        <= '0;
         cand_idx <= '0;
         wait_cnt <= '0;
         sad_cap  <= '0;
         err      <= 1'b0;
      end else if (accept) begin
         n        <= n_clamped;
         cand_idx <= '0;
         err      <= 1'b0;
      end else if (aborting) begin
         cand_idx <= '0;
      end else begin
         case (state)
            S_LAUNCH: wait_cnt <= '0;
            S_WAIT: begin
               if (bus.sad_done) begin
                  sad_cap <= bus.sad;
               end else if (timed_out) begin
                  err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_UPDATE: begin
               if (!last_cand) begin
                  cand_idx <= cand_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   sad_min_tracker #(
      .SAD_W (SAD_W),
      .IW    (IW)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .clear    (track_clear),
      .load     (track_load),
      .sad      (sad_cap),
      .idx      (cand_idx),
      .best_sad (best_sad),
      .best_idx (best_idx)
   );

   // Status outputs decode the state register only, so no input reaches an
   // output combinationally.
   assign bus.sad_go   = (state == S_LAUNCH);
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_FINISH);
   assign bus.err      = err;
   assign bus.cand_idx = cand_idx;
   assign bus.best_sad = best_sad;
   assign bus.best_idx = best_idx;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl
// Self-checking bench for sad_search_ctrl: an engine model answers sad_go after
// a programmable latency, and every search is checked against expectations
// derived directly from the search rules (min over candidates, lowest index on
// ties, timing n*(L+2), watchdog, abort and reset behaviour).
module tb_sad_search_ctrl;
   import sad_pkg::*;

   localparam int N_CAND  = 8;
   localparam int SAD_W   = 32;
   localparam int TIMEOUT = 16;
   localparam int BUDGET  = 400;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sad_search_ctrl_if #(.N_CAND(N_CAND), .SAD_W(SAD_W)) bus ();

   sad_search_ctrl #(
      .N_CAND  (N_CAND),
      .SAD_W   (SAD_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int go_count = 0;
   int go_wide = 0;
   int done_count = 0;
   logic prev_go = 1'b0;

   logic [31:0] eng_vals [0:N_CAND-1];
   int eng_lat = 1;
   int eng_silent = -1;
   bit eng_stray = 1'b0;
   logic eng_done = 1'b0;
   logic [31:0] eng_sad = '0;
   logic stray_done = 1'b0;

   logic [31:0] last_best = '1;
   int last_idx = 0;

   assign bus.sad_done = eng_done | stray_done;
   assign bus.sad      = eng_sad;

   // Free-running cycle counter; at a falling edge cyc names the last rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: counts launches, over-wide launch pulses and done pulses.
   always @(negedge clk) begin
      prev_go <= bus.sad_go;
      if (bus.sad_go) go_count <= go_count + 1;
      if (bus.sad_go && prev_go) go_wide <= go_wide + 1;
      if (bus.done) done_count <= done_count + 1;
   end

   // Engine model: after each launch it optionally emits a stray done in the
   // launch cycle, then answers L cycles after sad_go unless the candidate is
   // the silent one.
   initial begin
      int eng_idx;
      forever begin
         @(negedge clk);
         if (bus.sad_go) begin
            eng_idx = int'(bus.cand_idx);
            if (eng_stray) begin
               eng_sad  = '0;
               eng_done = 1'b1;
            end
            repeat (eng_lat) begin
               @(negedge clk);
               eng_done = 1'b0;
            end
            if (eng_idx != eng_silent) begin
               eng_sad  = eng_vals[eng_idx];
               eng_done = 1'b1;
               @(negedge clk);
               eng_done = 1'b0;
            end
         end
      end
   end

   // Global time limit so the bench can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed=running required=finished");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " sad_go"},   64'(bus.sad_go),   64'd0);
      checkOutput({tag, " busy"},     64'(bus.busy),     64'd0);
      checkOutput({tag, " done"},     64'(bus.done),     64'd0);
      checkOutput({tag, " err"},      64'(bus.err),      64'd0);
      checkOutput({tag, " cand_idx"}, 64'(bus.cand_idx), 64'd0);
      checkOutput({tag, " best_sad"}, 64'(bus.best_sad), 64'(SAD_MAX));
      checkOutput({tag, " best_idx"}, 64'(bus.best_idx), 64'd0);
   endtask

   task automatic randomVals();
      for (int i = 0; i < N_CAND; i++) begin
         case ($urandom_range(0, 3))
            0:       eng_vals[i] = 32'($urandom_range(0, 15));
            1:       eng_vals[i] = '1;
            default: eng_vals[i] = $urandom;
         endcase
      end
   endtask

   // One search: num requested candidates, engine latency lat, optional silent
   // candidate, optional stray done in LAUNCH and optional start noise while busy.
   task automatic applyStimulus(input string tag, input int num, input int lat, input int silent,
                                input bit stray, input bit noise);
      int n, k, t, done_cyc, goes0, exp_lat, exp_goes, midx;
      bit tout;
      logic [31:0] minv;
      n    = (num > N_CAND) ? N_CAND : num;
      tout = (silent >= 0) && (silent < n);
      k    = tout ? silent : n;
      minv = '1;
      for (int i = 0; i < k; i++) minv = (eng_vals[i] < minv) ? eng_vals[i] : minv;
      midx = 0;
      if (minv != '1) begin
         for (int i = k - 1; i >= 0; i--) if (eng_vals[i] == minv) midx = i;
      end
      exp_lat  = tout ? (k * (lat + 2) + 1 + TIMEOUT) : (n * (lat + 2));
      exp_goes = tout ? k + 1 : k;

      eng_lat = lat;
      eng_silent = silent;
      eng_stray = stray;
      goes0 = go_count;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num_cand = 4'(num);
      @(negedge clk);
      bus.start = 1'b0;
      t = cyc;
      checkOutput({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
      checkOutput({tag, " go_after_start"}, 64'(bus.sad_go), 64'(n > 0));
      done_cyc = -1;
      for (int i = 0; i < BUDGET && done_cyc < 0; i++) begin
         if (bus.done) begin
            done_cyc = cyc;
         end else begin
            if (noise && i == 3) begin
               bus.start = 1'b1;
               bus.num_cand = 4'd1;
            end else if (noise && i == 4) begin
               bus.start = 1'b0;
            end
            @(negedge clk);
         end
      end
      bus.start = 1'b0;
      checkOutput({tag, " done_latency"}, (done_cyc < 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(done_cyc - t), 64'(exp_lat));
      checkOutput({tag, " best_sad"}, 64'(bus.best_sad), 64'(minv));
      checkOutput({tag, " best_idx"}, 64'(bus.best_idx), 64'(midx));
      checkOutput({tag, " err"}, 64'(bus.err), 64'(tout));
      @(negedge clk);
      checkOutput({tag, " busy_after_done"}, 64'(bus.busy), 64'd0);
      checkOutput({tag, " done_width"}, 64'(bus.done), 64'd0);
      checkOutput({tag, " err_held"}, 64'(bus.err), 64'(tout));
      checkOutput({tag, " best_sad_held"}, 64'(bus.best_sad), 64'(minv));
      checkOutput({tag, " go_pulses"}, 64'(go_count - goes0), 64'(exp_goes));
      checkOutput({tag, " go_width"}, 64'(go_wide), 64'd0);
      last_best = minv;
      last_idx = midx;
   endtask

   initial begin
      int found, done0, goes0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.num_cand = '0;
      for (int i = 0; i < N_CAND; i++) eng_vals[i] = '0;

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;

      // Directed normal search with a tie on the minimum.
      eng_vals[0] = 32'd50;
      eng_vals[1] = 32'd20;
      eng_vals[2] = 32'd35;
      eng_vals[3] = 32'd20;
      applyStimulus("normal", 4, 4, -1, 1'b0, 1'b0);

      // Zero candidates and clamping above N_CAND (with stray done in LAUNCH
      // and a start pulse while busy).
      applyStimulus("zero", 0, 3, -1, 1'b0, 1'b0);
      randomVals();
      applyStimulus("clamp", 9, 2, -1, 1'b1, 1'b1);

      // Stray sad_done in IDLE must not start or change anything.
      goes0 = go_count;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      @(negedge clk);
      checkOutput("stray_idle busy", 64'(bus.busy), 64'd0);
      checkOutput("stray_idle best_sad", 64'(bus.best_sad), 64'(last_best));
      checkOutput("stray_idle best_idx", 64'(bus.best_idx), 64'(last_idx));
      checkOutput("stray_idle go_pulses", 64'(go_count - goes0), 64'd0);

      // Watchdog: engine silent on candidate 2.
      randomVals();
      applyStimulus("timeout", 5, 3, 2, 1'b0, 1'b0);

      // Randomized searches.
      for (int r = 0; r < 8; r++) begin
         randomVals();
         applyStimulus($sformatf("rand%0d", r), int'($urandom_range(0, 10)), int'($urandom_range(1, 6)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                       1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort in WAIT of candidate 1, coincident with sad_done.
      randomVals();
      eng_lat = 3;
      eng_silent = -1;
      eng_stray = 1'b0;
      done0 = done_count;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num_cand = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < BUDGET && found == 0; i++) begin
         @(negedge clk);
         #1;
         if (bus.sad_done && bus.cand_idx == 3'd1) found = 1;
      end
      checkOutput("abort reached", 64'(found), 64'd1);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      checkOutput("abort busy", 64'(bus.busy), 64'd0);
      checkOutput("abort best_sad", 64'(bus.best_sad), 64'(SAD_MAX));
      checkOutput("abort best_idx", 64'(bus.best_idx), 64'd0);
      checkOutput("abort cand_idx", 64'(bus.cand_idx), 64'd0);
      checkOutput("abort err", 64'(bus.err), 64'd0);
      repeat (4) @(negedge clk);
      checkOutput("abort no_done", 64'(done_count - done0), 64'd0);
      checkOutput("abort still_idle", 64'(bus.busy), 64'd0);

      // Asynchronous reset in the middle of an UPDATE cycle.
      randomVals();
      eng_lat = 3;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num_cand = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < BUDGET && found == 0; i++) begin
         @(negedge clk);
         #1;
         if (bus.sad_done) found = 1;
      end
      checkOutput("midreset reached", 64'(found), 64'd1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkResetValues("midreset");
      @(negedge clk);
      rst = 1'b0;

      // Clean full search after reset release.
      randomVals();
      applyStimulus("post_reset", 8, 2, -1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Scheduler sitting above the SAD engine: on one `start` it runs the engine once per candidate block, drives the candidate index onto the engine's upper B-address bits, and tracks the minimum SAD and its index. A watchdog terminates the search if the engine never returns `sad_done`. It turns the single-block SAD unit into a full-search motion-estimation step.

## Interface
- `N_CAND`, 8, maximum candidates per search (≥1); `IW = $clog2(N_CAND)`, `CW = $clog2(N_CAND+1)`
- `SAD_W`, 32, SAD result width
- `TIMEOUT`, 1024, max cycles waiting for `sad_done` per candidate
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: single-cycle request, sampled in IDLE only
- `abort` in 1: cancels a running search
- `num_cand` in CW: candidates this search, latched on accepted `start`
- `sad_done` in 1: engine completion pulse
- `sad` in SAD_W: engine result, valid when `sad_done`=1
- `sad_go` out 1: one-cycle launch pulse to engine
- `cand_idx` out IW: current candidate, stable from `sad_go` until `sad_done`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle completion pulse
- `err` out 1: search ended by timeout; held until next accepted `start`
- `best_sad` out SAD_W: minimum SAD found
- `best_idx` out IW: index of `best_sad`

## Operation
- States: IDLE, LAUNCH, WAIT, UPDATE, FINISH.
- IDLE: `start`=1 & `abort`=0 → latch `n = min(num_cand, N_CAND)`, clear `err`, `best_sad`←all ones, `best_idx`←0, `cand_idx`←0. If `n`=0 → FINISH, else → LAUNCH.
- LAUNCH: `sad_go`=1 for exactly this cycle; clear wait counter; → WAIT.
- WAIT: `sad_done`=1 → capture `sad`, → UPDATE. Counter reaches TIMEOUT-1 without `sad_done` → set `err`, → FINISH.
- UPDATE: strictly smaller captured SAD → `best_sad`←SAD, `best_idx`←`cand_idx`. On ties, lower index is kept. If `cand_idx`==`n`-1 → FINISH, else `cand_idx`++ → LAUNCH.
- FINISH: `done`=1 → IDLE.
- `abort`=1 in any non-IDLE state → IDLE next cycle:
  - no `done`, `err` unchanged.
  - `best_*` return to reset values.
  - `cand_idx`←0.
- Priority: `abort` > `sad_done` > timeout.
- `start` outside IDLE is ignored. `sad_done` outside WAIT is ignored.
- Comparison is unsigned SAD_W-bit. No arithmetic on `sad` beyond compare.

## Timing
- Reset values: `sad_go`=0, `busy`=0, `done`=0, `err`=0, `cand_idx`=0, `best_sad`=all ones, `best_idx`=0; state IDLE.
- `start` accepted at edge t:
  - LAUNCH (`sad_go`=1) in cycle t+1.
  - Engine returns `sad_done` L≥1 cycles after `sad_go`.
  - Per candidate: L+2 cycles.
  - `done` arrives 1 + n·(L+2) cycles after acceptance.
- `n`=0: `done` in cycle t+1. `best_sad`=all ones, `best_idx`=0.
- `best_sad`/`best_idx`:
  - updated at the end of UPDATE.
  - final in the FINISH cycle.
  - held until the next accepted `start`.
- All outputs registered. No combinational path from inputs to outputs.
- Back-to-back: `start` in the cycle after FINISH (IDLE) is accepted.

## Structure
- `sad_pkg`: state enum typedef `sad_sched_state_t`, `SAD_W` default, `SAD_MAX` (all-ones) constant.
- One sub-module, `sad_min_tracker`:
  - inputs: clear, load-enable, SAD value, index.
  - outputs: registered `best_sad`/`best_idx`.
  - strict-less compare.
- FSM, wait counter and `cand_idx` counter live in the top.

## Test plan
- Normal search: N_CAND=8, `num_cand`=4, engine model L=4 returning SADs 50, 20, 35, 20 → `done` 25 cycles after start, `best_sad`=20, `best_idx`=1 (tie keeps lower), `err`=0.
- Zero / clamp:
  - `num_cand`=0 → `done` next cycle, `best_sad`=32'hFFFF_FFFF, `best_idx`=0, no `sad_go`.
  - `num_cand`=9 → exactly 8 `sad_go` pulses.
- Timeout: TIMEOUT=16, engine silent on candidate 2 → `err`=1, `done` 1 cycle after 16 WAIT cycles. `best_*` hold the min of candidates 0–1.
- Abort: abort asserted in WAIT of candidate 1, same cycle as `sad_done` → IDLE next cycle, no `done`, `best_sad` all ones, `busy`=0.
- Protocol noise:
  - `start` pulsed while `busy` → ignored, search count unchanged.
  - stray `sad_done` in IDLE/LAUNCH → ignored.
  - `sad_go` is always 1 cycle wide.
- Reset mid-search: `rst` asserted asynchronously mid-cycle in UPDATE → all outputs at reset values immediately. A new `start` after release runs a full clean search.
